hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Stall/forward controller for the 5-stage pipeline; consumes the D-stage decoder's per-instruction control outputs.
//  Keeps a shadow pipeline of in-flight destination registers for E/M/W, tracked with Tnew/Tuse.
//  Drives stall (freeze PC and F/D, bubble into D/E) and mux selects for the D- and E-stage forwarding paths.
//  W->D forwarding is done by the GRF's internal write-through bypass, not here.
// PARAMETERS
//  REG_AW   5   register address width
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-low: reset==1'b0 at posedge clears all state
//  d_rs          in   5   D-stage rs field
//  d_rt          in   5   D-stage rt field
//  d_tuse_rs     in   2   cycles until rs needed (0 Branch/Jr, 1 ALU, 3 = unused)
//  d_tuse_rt     in   2   cycles until rt needed (0 beq, 1 R-type ALU, 2 sw/sb, 3 = unused)
//  d_regwrite    in   1   decoder RegWrite
//  d_dst         in   5   final dest (rd / rt / 31 for jal) from the RegDst/Jal mux
//  d_tnew        in   2   cycles from E entry until result ready (0 jal, 1 ALU, 2 lw/lb)
//  stall         out  1   1 = hold PC and F/D, load bubble into D/E
//  fwd_d_rs_sel  out  2   D-stage rs mux: 0 GRF, 1 E, 2 M
//  fwd_d_rt_sel  out  2   D-stage rt mux: same encoding
//  fwd_e_rs_sel  out  2   E-stage rs mux: 0 D/E reg, 2 M, 3 W
//  fwd_e_rt_sel  out  2   E-stage rt mux: same encoding
// BEHAVIOUR
//  State: slots E, M, W, each {we, dst[4:0], tnew[1:0]}; plus e_rs, e_rt latched with the E slot.
//  Reset: every slot we=0, dst=0, tnew=0, e_rs=e_rt=0; hence stall=0 and all selects 0 in the next cycle.
//  Advance each cycle when reset==1: W<=M; M<=E with tnew=sat_dec(E.tnew).
//   E<=bubble (we=0, dst=0, tnew=0, e_rs=e_rt=0) if stall, else {d_regwrite, d_dst, d_tnew, d_rs, d_rt}.
//   W.tnew is always 0.
//  Match(slot,src) = slot.we & (slot.dst==src) & (src!=0). Register $0 never stalls and never forwards.
//  stall (combinational) = any src in {rs,rt} with tuse!=3 such that
//   Match(E,src) & tuse<E.tnew, or Match(M,src) & tuse<M.tnew.
//  fwd_d_*: 1 if Match(E,src) & E.tnew==0; else 2 if Match(M,src) & M.tnew==0; else 0. E has priority.
//  fwd_e_*: 2 if Match(M,e_src) & M.tnew==0; else 3 if Match(W,e_src); else 0. M has priority.
//  Forward selects are valid whether or not stall is asserted; they are don't-care for the bubbled consumer.
//  Stall never exceeds 2 consecutive cycles (max Tnew 2, min Tuse 0).
//  A D instruction with a dst match in both E and M resolves against the youngest producer (E).
//  Reset asserted mid-stall: slots clear at that edge, and stall drops the next cycle regardless of D inputs.
//  Branch delay slot is preserved; no flush output.
// STRUCTURE
//  constant.v: `tnewAlu/`tnewLd/`tnewJal, `tuseNone(2'd3), `fwdRf/`fwdE/`fwdM/`fwdW encodings.
//  Sub-module hz_slot: one registered {we,dst,tnew}, with load/bubble/reset and a sat-decrement output.
//   Instantiated 3 times.
//  Match, stall and select logic is combinational in the top level.
// TESTING
//  lw $1 -> add $2,$1,$3: stall=1 for 1 cycle; then fwd_e_rs_sel=3 when add is in E and lw is in W.
//  lw $1 -> beq $1,$0: stall for 2 cycles; third cycle stall=0, fwd_d_rs_sel=0 (GRF bypass).
//  add $4 -> beq $4,$5: stall 1 cycle; then fwd_d_rs_sel=2.
//  add $4 -> sub $6,$4,$4: no stall; fwd_e_rs_sel=fwd_e_rt_sel=2.
//  jal -> jr $31 in delay slot: no stall; fwd_d_rs_sel=1.
//  lw $1 -> sw $1: no stall (tuse 2).
//  ori $0 -> beq $0: no stall; all selects 0.
//  reset=0 during lw->beq stall: next cycle stall=0 and slots are empty.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types, encodings and match/select helpers for the pipeline hazard controller.
// Tnew/Tuse are cycle counts; selects use the fwd_* encodings below.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned TUSE_W = 2;
  localparam int unsigned SEL_W  = 2;

  localparam logic [TNEW_W-1:0] TNEW_JAL  = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LD   = 2'd2;
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  localparam logic [SEL_W-1:0] FWD_RF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_E  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_M  = 2'd2;
  localparam logic [SEL_W-1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] dst;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // $0 is hard-wired, so it never matches a producer.
  function automatic logic reg_match(input logic              we,
                                     input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src);
    return we && (dst == src) && (src != '0);
  endfunction

  function automatic logic src_stall(input logic [REG_AW-1:0] src,
                                     input logic [TUSE_W-1:0] tuse,
                                     input slot_t             e,
                                     input slot_t             m);
    return (tuse != TUSE_NONE) &&
           ((reg_match(e.we, e.dst, src) && (tuse < e.tnew)) ||
            (reg_match(m.we, m.dst, src) && (tuse < m.tnew)));
  endfunction

  // Youngest ready producer wins.
  function automatic logic [SEL_W-1:0] fwd_d_sel(input logic [REG_AW-1:0] src,
                                                 input slot_t             e,
                                                 input slot_t             m);
    if (reg_match(e.we, e.dst, src) && (e.tnew == '0)) return FWD_E;
    if (reg_match(m.we, m.dst, src) && (m.tnew == '0)) return FWD_M;
    return FWD_RF;
  endfunction

  function automatic logic [SEL_W-1:0] fwd_e_sel(input logic [REG_AW-1:0] src,
                                                 input slot_t             m,
                                                 input slot_t             w);
    if (reg_match(m.we, m.dst, src) && (m.tnew == '0)) return FWD_M;
    if (reg_match(w.we, w.dst, src) && (w.tnew == '0)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder-to-hazard-controller bundle: D-stage control fields in, stall and forward selects out.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
();

  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TUSE_W-1:0] d_tuse_rs;
  logic [TUSE_W-1:0] d_tuse_rt;
  logic              d_regwrite;
  logic [REG_AW-1:0] d_dst;
  logic [TNEW_W-1:0] d_tnew;

  logic              stall;
  logic [SEL_W-1:0]  fwd_d_rs_sel;
  logic [SEL_W-1:0]  fwd_d_rt_sel;
  logic [SEL_W-1:0]  fwd_e_rs_sel;
  logic [SEL_W-1:0]  fwd_e_rt_sel;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_dst, d_tnew,
    input  stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_dst, d_tnew,
    output stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel
  );

endinterface

// File: rtl/hazard_ctrl_hz_slot.sv
// One shadow-pipeline slot {we, dst, tnew}; loads every cycle, optionally sat-decrementing tnew,
// and takes a bubble instead of din when bubble is set.
module hazard_ctrl_hz_slot
  import hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  logic  dec,
  input  slot_t din,
  output slot_t q
);

  slot_t slot_d;
  slot_t slot_q;

  always_comb begin
    slot_d = din;
    if (dec) slot_d.tnew = sat_dec(din.tnew);
    if (bubble) slot_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign q = slot_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline, tracking E/M/W destinations with Tnew/Tuse.
// W->D forwarding is left to the register file's write-through bypass.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hif
);

  slot_t             e_din;
  slot_t             e_q;
  slot_t             m_q;
  slot_t             w_q;
  logic [REG_AW-1:0] e_rs_d;
  logic [REG_AW-1:0] e_rs_q;
  logic [REG_AW-1:0] e_rt_d;
  logic [REG_AW-1:0] e_rt_q;
  logic              stall_c;

  always_comb begin
    e_din   = '{we: hif.d_regwrite, dst: hif.d_dst, tnew: hif.d_tnew};
    stall_c = src_stall(hif.d_rs, hif.d_tuse_rs, e_q, m_q) |
              src_stall(hif.d_rt, hif.d_tuse_rt, e_q, m_q);
    e_rs_d  = stall_c ? '0 : hif.d_rs;
    e_rt_d  = stall_c ? '0 : hif.d_rt;
  end

  // Source registers of the instruction now in E, for the E-stage muxes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_rs_q <= '0;
      e_rt_q <= '0;
    end else begin
      e_rs_q <= e_rs_d;
      e_rt_q <= e_rt_d;
    end
  end

  hazard_ctrl_hz_slot u_slot_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall_c),
    .dec    (1'b0),
    .din    (e_din),
    .q      (e_q)
  );

  hazard_ctrl_hz_slot u_slot_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b1),
    .din    (e_q),
    .q      (m_q)
  );

  hazard_ctrl_hz_slot u_slot_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b1),
    .din    (m_q),
    .q      (w_q)
  );

  assign hif.stall        = stall_c;
  assign hif.fwd_d_rs_sel = fwd_d_sel(hif.d_rs, e_q, m_q);
  assign hif.fwd_d_rt_sel = fwd_d_sel(hif.d_rt, e_q, m_q);
  assign hif.fwd_e_rs_sel = fwd_e_sel(e_rs_q, m_q, w_q);
  assign hif.fwd_e_rt_sel = fwd_e_sel(e_rt_q, m_q, w_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one vector per cycle, D inputs driven after posedge,
// combinational outputs checked on the following negedge against hand-computed values.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       we;
    logic [4:0] dst;
    logic [1:0] tnew;
  } instr_t;

  typedef struct {
    string      name;
    logic       rst_n;
    instr_t     ins;
    logic       stall;
    logic [1:0] f_drs;
    logic [1:0] f_drt;
    logic [1:0] f_ers;
    logic [1:0] f_ert;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  hazard_ctrl_if hif();

  hazard_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk_i(logic [4:0] rs, logic [4:0] rt, logic [1:0] urs, logic [1:0] urt,
                                  logic we, logic [4:0] dst, logic [1:0] tnew);
    instr_t i;
    i.rs = rs; i.rt = rt; i.tuse_rs = urs; i.tuse_rt = urt;
    i.we = we; i.dst = dst; i.tnew = tnew;
    return i;
  endfunction

  function automatic instr_t i_nop();
    return mk_i(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, 2'd0);
  endfunction
  function automatic instr_t i_lw(logic [4:0] rt, logic [4:0] base);
    return mk_i(base, rt, 2'd1, TUSE_NONE, 1'b1, rt, TNEW_LD);
  endfunction
  function automatic instr_t i_add(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return mk_i(rs, rt, 2'd1, 2'd1, 1'b1, rd, TNEW_ALU);
  endfunction
  function automatic instr_t i_ori(logic [4:0] rt, logic [4:0] rs);
    return mk_i(rs, rt, 2'd1, TUSE_NONE, 1'b1, rt, TNEW_ALU);
  endfunction
  function automatic instr_t i_beq(logic [4:0] rs, logic [4:0] rt);
    return mk_i(rs, rt, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
  endfunction
  function automatic instr_t i_sw(logic [4:0] rt, logic [4:0] base);
    return mk_i(base, rt, 2'd1, 2'd2, 1'b0, 5'd0, 2'd0);
  endfunction
  function automatic instr_t i_jal();
    return mk_i(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b1, 5'd31, TNEW_JAL);
  endfunction
  function automatic instr_t i_jr(logic [4:0] rs);
    return mk_i(rs, 5'd0, 2'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0);
  endfunction

  function automatic vec_t mk(string name, logic rst_n, instr_t ins, logic st,
                              logic [1:0] fdrs, logic [1:0] fdrt, logic [1:0] fers, logic [1:0] fert);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.ins = ins; v.stall = st;
    v.f_drs = fdrs; v.f_drt = fdrt; v.f_ers = fers; v.f_ert = fert;
    return v;
  endfunction

  task automatic chk(string what, logic [1:0] act, logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  task automatic drive(instr_t i);
    hif.d_rs       = i.rs;
    hif.d_rt       = i.rt;
    hif.d_tuse_rs  = i.tuse_rs;
    hif.d_tuse_rt  = i.tuse_rt;
    hif.d_regwrite = i.we;
    hif.d_dst      = i.dst;
    hif.d_tnew     = i.tnew;
  endtask

  task automatic step(vec_t v);
    reset = v.rst_n;
    drive(v.ins);
    @(negedge clk);
    chk({v.name, " stall"},        {1'b0, hif.stall}, {1'b0, v.stall});
    chk({v.name, " fwd_d_rs_sel"}, hif.fwd_d_rs_sel,  v.f_drs);
    chk({v.name, " fwd_d_rt_sel"}, hif.fwd_d_rt_sel,  v.f_drt);
    chk({v.name, " fwd_e_rs_sel"}, hif.fwd_e_rs_sel,  v.f_ers);
    chk({v.name, " fwd_e_rt_sel"}, hif.fwd_e_rt_sel,  v.f_ert);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(i_nop());
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mk("reset_state", 1, i_nop(), 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // lw $1 -> add $2,$1,$3
    tbl.push_back(mk("a_lw",        1, i_lw(5'd1, 5'd29),        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("a_add_stall", 1, i_add(5'd2, 5'd1, 5'd3),  1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("a_add_go",    1, i_add(5'd2, 5'd1, 5'd3),  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("a_add_in_e",  1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_W,  FWD_RF));
    tbl.push_back(mk("a_drain0",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("a_drain1",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // lw $1 -> beq $1,$0
    tbl.push_back(mk("b_lw",        1, i_lw(5'd1, 5'd29),        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("b_beq_st1",   1, i_beq(5'd1, 5'd0),        1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("b_beq_st2",   1, i_beq(5'd1, 5'd0),        1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("b_beq_go",    1, i_beq(5'd1, 5'd0),        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("b_drain0",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("b_drain1",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // add $4 -> beq $4,$5
    tbl.push_back(mk("c_add",       1, i_add(5'd4, 5'd5, 5'd6),  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("c_beq_stall", 1, i_beq(5'd4, 5'd5),        1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("c_beq_fwd_m", 1, i_beq(5'd4, 5'd5),        0, FWD_M,  FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("c_beq_in_e",  1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_W,  FWD_RF));
    tbl.push_back(mk("c_drain",     1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // add $4 -> sub $6,$4,$4
    tbl.push_back(mk("d_add",       1, i_add(5'd4, 5'd5, 5'd6),  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("d_sub",       1, i_add(5'd6, 5'd4, 5'd4),  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("d_sub_in_e",  1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_M,  FWD_M));
    tbl.push_back(mk("d_drain0",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("d_drain1",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // jal -> jr $31
    tbl.push_back(mk("e_jal",       1, i_jal(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("e_jr_fwd_e",  1, i_jr(5'd31),              0, FWD_E,  FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("e_jr_in_e",   1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_M,  FWD_RF));
    tbl.push_back(mk("e_drain",     1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // lw $1 -> sw $1
    tbl.push_back(mk("f_lw",        1, i_lw(5'd1, 5'd29),        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("f_sw",        1, i_sw(5'd1, 5'd29),        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("f_sw_in_e",   1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("f_drain",     1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // ori $0 -> beq $0,$0
    tbl.push_back(mk("g_ori0",      1, i_ori(5'd0, 5'd0),        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("g_beq0",      1, i_beq(5'd0, 5'd0),        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("g_drain0",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("g_drain1",    1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // jal, jal -> jr $31: E beats M in D, M beats W in E
    tbl.push_back(mk("h_jal0",      1, i_jal(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("h_jal1",      1, i_jal(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("h_jr_prio",   1, i_jr(5'd31),              0, FWD_E,  FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("h_jr_in_e",   1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_M,  FWD_RF));
    tbl.push_back(mk("h_drain",     1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    // add $9 -> beq $0,$9 exercises the rt path
    tbl.push_back(mk("i_add",       1, i_add(5'd9, 5'd5, 5'd6),  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("i_beq_stall", 1, i_beq(5'd0, 5'd9),        1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    tbl.push_back(mk("i_beq_fwd_m", 1, i_beq(5'd0, 5'd9),        0, FWD_RF, FWD_M,  FWD_RF, FWD_RF));
    tbl.push_back(mk("i_beq_in_e",  1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_W));
    tbl.push_back(mk("i_drain",     1, i_nop(),                  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));

    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

    // Reset pulled during the second cycle of a lw->beq stall.
    step(mk("r_lw",        1, i_lw(5'd1, 5'd29), 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    step(mk("r_beq_stall", 1, i_beq(5'd1, 5'd0), 1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    step(mk("r_rst_edge",  0, i_beq(5'd1, 5'd0), 1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    step(mk("r_after_rst", 1, i_beq(5'd1, 5'd0), 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    step(mk("r_empty",     1, i_nop(),           0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));

    // Reset held low for two edges must not capture the D instruction.
    step(mk("hr_lw",       1, i_lw(5'd1, 5'd29), 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    step(mk("hr_rst0",     0, i_beq(5'd1, 5'd0), 1, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    step(mk("hr_rst1",     0, i_lw(5'd1, 5'd29), 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));
    step(mk("hr_beq",      1, i_beq(5'd1, 5'd0), 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
